shiftreg_universal: RTL and testbench

Parametrised universal shift register that combines the SISO, SIPO, PISO and PIPO behaviours in one mode-selected block. It also adds left/right shift, rotate, synchronous clear and a word-boundary counter with a word-valid strobe. It is the building block for the serialiser/deserialiser paths. A single instance replaces a fixed-direction register of any flavour.

---
 rtl/shiftreg_universal.sv | 100 ++++++++++
 tb/tb_shiftreg_universal.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/shiftreg_universal.sv
// Universal shift register: hold/load/shift-left/shift-right/rotate/clear with a word-boundary counter.
// Latency: one cycle from the sampling edge to the visible register contents and strobe.
// Backpressure: none; en=0 freezes all state and suppresses the word strobe.
module shiftreg_universal #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [2:0]            mode,
   input  logic                  in_serial_l,
   input  logic                  in_serial_r,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_serial_l,
   output logic                  out_serial_r,
   output logic [CNT_WIDTH-1:0]  out_shift_cnt,
   output logic                  out_word_vld
);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_ROL   = 3'b100,
      MODE_ROR   = 3'b101,
      MODE_CLEAR = 3'b110,
      MODE_RSVD  = 3'b111
   } mode_e;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  vld_q, vld_d;
   logic                  advance;

   // Next-state decode; everything defaults to hold so idle and reserved cases stay defined.
   always_comb begin
      data_d  = data_q;
      cnt_d   = cnt_q;
      vld_d   = 1'b0;
      advance = 1'b0;
      if (en) begin
         case (mode_e'(mode))
            MODE_LOAD: begin
               data_d = in_data;
               cnt_d  = '0;
            end
            MODE_SHL: begin
               data_d  = {data_q[DATA_WIDTH-2:0], in_serial_l};
               advance = 1'b1;
            end
            MODE_SHR: begin
               data_d  = {in_serial_r, data_q[DATA_WIDTH-1:1]};
               advance = 1'b1;
            end
            MODE_ROL:   data_d = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
            MODE_ROR:   data_d = {data_q[0], data_q[DATA_WIDTH-1:1]};
            MODE_CLEAR: begin
               data_d = '0;
               cnt_d  = '0;
            end
            default: ; // HOLD and the reserved code leave state untouched
         endcase
      end
      // Both shift directions share one counter; a wrap marks a completed word.
      if (advance) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            vld_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   // State registers; the strobe is rewritten every cycle so it lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

   assign out_data      = data_q;
   assign out_serial_l  = data_q[DATA_WIDTH-1];
   assign out_serial_r  = data_q[0];
   assign out_shift_cnt = cnt_q;
   assign out_word_vld  = vld_q;

endmodule

// File: tb/tb_shiftreg_universal.sv
// Directed bench for shiftreg_universal at DATA_WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants.
module tb_shiftreg_universal;

   localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010, M_SHR = 3'b011,
                          M_ROL = 3'b100, M_ROR = 3'b101, M_CLR = 3'b110, M_RSVD = 3'b111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] mode;
   logic       in_serial_l;
   logic       in_serial_r;
   logic [7:0] in_data;
   logic [7:0] out_data;
   logic       out_serial_l;
   logic       out_serial_r;
   logic [2:0] out_shift_cnt;
   logic       out_word_vld;

   int total = 0;
   int bad   = 0;

   shiftreg_universal #(.DATA_WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .mode         (mode),
      .in_serial_l  (in_serial_l),
      .in_serial_r  (in_serial_r),
      .in_data      (in_data),
      .out_data     (out_data),
      .out_serial_l (out_serial_l),
      .out_serial_r (out_serial_r),
      .out_shift_cnt(out_shift_cnt),
      .out_word_vld (out_word_vld)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic e, input logic [2:0] m, input logic sl, input logic sr,
                       input logic [7:0] d);
      en = e; mode = m; in_serial_l = sl; in_serial_r = sr; in_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [7:0] d, input logic [2:0] c,
                            input logic v);
      chk({tag, ".data"}, 64'(out_data), 64'(d));
      chk({tag, ".cnt"},  64'(out_shift_cnt), 64'(c));
      chk({tag, ".vld"},  64'(out_word_vld), 64'(v));
   endtask

   logic [7:0] sipo_bits;
   logic [7:0] piso_exp;
   int         strobes;

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = M_HOLD;
      in_serial_l = 1'b0; in_serial_r = 1'b0; in_data = 8'h00;
      #12;
      chk_state("reset", 8'h00, 3'd0, 1'b0);
      rst_n = 1'b1;

      // SIPO: bits 1,0,1,1,0,0,1,0 entering on the left assemble 0xB2
      sipo_bits = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, M_SHL, sipo_bits[7-i], 1'b0, 8'h00);
         if (i < 7) begin
            chk($sformatf("sipo.cnt%0d", i), 64'(out_shift_cnt), 64'(i + 1));
            chk($sformatf("sipo.vld%0d", i), 64'(out_word_vld), 64'd0);
         end
      end
      chk_state("sipo.word", 8'hB2, 3'd0, 1'b1);
      chk("sipo.msb", 64'(out_serial_l), 64'd1);
      step(1'b1, M_HOLD, 1'b0, 1'b0, 8'h00);
      chk_state("sipo.after", 8'hB2, 3'd0, 1'b0);

      // PISO: 0xA5 leaves LSB first as 1,0,1,0,0,1,0,1
      step(1'b1, M_LOAD, 1'b0, 1'b0, 8'hA5);
      chk_state("piso.load", 8'hA5, 3'd0, 1'b0);
      piso_exp = 8'b1010_0101;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("piso.ser%0d", i), 64'(out_serial_r), 64'(piso_exp[i]));
         step(1'b1, M_SHR, 1'b0, 1'b0, 8'h00);
         if (i < 7) chk($sformatf("piso.vld%0d", i), 64'(out_word_vld), 64'd0);
      end
      chk_state("piso.done", 8'h00, 3'd0, 1'b1);

      // Rotates leave the counter alone and never strobe
      step(1'b1, M_LOAD, 1'b0, 1'b0, 8'h81);
      step(1'b1, M_ROL, 1'b0, 1'b0, 8'h00);
      chk_state("rol1", 8'h03, 3'd0, 1'b0);
      step(1'b1, M_ROR, 1'b0, 1'b0, 8'h00);
      chk_state("ror1", 8'h81, 3'd0, 1'b0);
      step(1'b1, M_ROR, 1'b0, 1'b0, 8'h00);
      chk_state("ror2", 8'hC0, 3'd0, 1'b0);

      // Enable/hold: 4 shifts, en=0 (with SHL requested), reserved mode, then finish the word
      step(1'b1, M_LOAD, 1'b0, 1'b0, 8'h00);
      step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      step(1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
      step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      chk_state("hold.four", 8'h0D, 3'd4, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, M_SHL, 1'b1, 1'b1, 8'hFF);
      chk_state("hold.en0", 8'h0D, 3'd4, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, M_RSVD, 1'b1, 1'b1, 8'hFF);
      chk_state("hold.rsvd", 8'h0D, 3'd4, 1'b0);
      strobes = 0;
      step(1'b1, M_SHL, 1'b0, 1'b0, 8'h00); if (out_word_vld) strobes++;
      step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00); if (out_word_vld) strobes++;
      step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00); if (out_word_vld) strobes++;
      step(1'b1, M_SHL, 1'b0, 1'b0, 8'h00); if (out_word_vld) strobes++;
      chk_state("hold.word", 8'hD6, 3'd0, 1'b1);
      step(1'b1, M_HOLD, 1'b0, 1'b0, 8'h00); if (out_word_vld) strobes++;
      chk("hold.strobes", 64'(strobes), 64'd1);

      // Mixed directions share one counter: SHL/SHR alternating, 8 shifts make a word
      for (int i = 0; i < 8; i++) begin
         step(1'b1, (i % 2 == 0) ? M_SHL : M_SHR, 1'b0, 1'b0, 8'h00);
         if (i == 6) chk("mixed.cnt7", 64'(out_shift_cnt), 64'd7);
      end
      chk("mixed.vld", 64'(out_word_vld), 64'd1);

      // Collision: LOAD / CLEAR on the would-be wrap cycle
      step(1'b1, M_CLR, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      chk_state("coll.seven", 8'h7F, 3'd7, 1'b0);
      step(1'b1, M_LOAD, 1'b1, 1'b0, 8'h3C);
      chk_state("coll.load", 8'h3C, 3'd0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      chk("coll.cnt7b", 64'(out_shift_cnt), 64'd7);
      step(1'b1, M_CLR, 1'b1, 1'b0, 8'h00);
      chk_state("coll.clear", 8'h00, 3'd0, 1'b0);

      // Asynchronous reset mid-word at counter=5, observed before any edge
      for (int i = 0; i < 5; i++) step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      chk_state("rst.pre", 8'h1F, 3'd5, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_state("rst.async", 8'h00, 3'd0, 1'b0);
      #2 rst_n = 1'b1;
      step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      chk_state("rst.resume", 8'h01, 3'd1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
